// File: rtl/laikas_stim.sv
// Stimulus generator for the LAIKAS elapsed-time counter:
// fires START/STOP a programmed interval apart, then grades the returned count.
module laikas_stim #(
  parameter int PW     = 3,
  parameter int SETTLE = 4,
  parameter int TOL    = 2
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        GO,
  input  logic        ABORT,
  input  logic [31:0] INTERVAL,
  input  logic [31:0] LAIKAS,
  output logic        START,
  output logic        STOP,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] MEAS,
  output logic        ERR
);

  typedef enum logic [2:0] {
    IDLE,
    START_P,
    GAP,
    STOP_P,
    SETTLE_W,
    DONE_S
  } state_t;

  localparam logic [31:0] PW_C   = 32'(PW);
  localparam logic [31:0] MIN_IV = 32'(PW + 1);
  localparam logic [31:0] SET_C  = 32'(SETTLE - 2);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] iv;
  logic        armed;

  logic [31:0] ieff_in;
  logic [32:0] diff;
  logic [32:0] mag;
  logic        ovr;

  // Difference is taken 33 bits wide so full-scale values never wrap.
  always_comb begin
    ieff_in = (INTERVAL < MIN_IV) ? MIN_IV : INTERVAL;
    diff    = {1'b0, LAIKAS} - {1'b0, iv};
    mag     = diff[32] ? (33'd0 - diff) : diff;
    ovr     = mag > 33'(TOL);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
      iv    <= '0;
      armed <= 1'b0;
      START <= 1'b0;
      STOP  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      MEAS  <= '0;
      ERR   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (ABORT && state != IDLE) begin
        state <= IDLE;
        cnt   <= '0;
        START <= 1'b0;
        STOP  <= 1'b0;
        BUSY  <= 1'b0;
        DONE  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (GO && !ABORT && armed) begin
              iv    <= ieff_in;
              cnt   <= PW_C - 32'd1;
              START <= 1'b1;
              BUSY  <= 1'b1;
              state <= START_P;
            end
          end
          START_P: begin
            if (cnt == '0) begin
              START <= 1'b0;
              cnt   <= iv - PW_C - 32'd1;
              state <= GAP;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              STOP  <= 1'b1;
              cnt   <= PW_C - 32'd1;
              state <= STOP_P;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          STOP_P: begin
            if (cnt == '0) begin
              STOP <= 1'b0;
              if (SETTLE == 1) begin
                MEAS  <= LAIKAS;
                ERR   <= ovr;
                DONE  <= 1'b1;
                state <= DONE_S;
              end else begin
                cnt   <= SET_C;
                state <= SETTLE_W;
              end
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          SETTLE_W: begin
            if (cnt == '0) begin
              MEAS  <= LAIKAS;
              ERR   <= ovr;
              DONE  <= 1'b1;
              state <= DONE_S;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          DONE_S: begin
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/laikas_stim.md
LAIKAS_STIM -- requirements
Module: laikas_stim

Interface
REQ-001 SHALL have parameter PW, default 3, giving the START/STOP pulse width in clock cycles (legal range 1..255).
REQ-002 SHALL have parameter SETTLE, default 4, giving the cycles waited after STOP falls before LAIKAS is sampled (legal range 1..255).
REQ-003 SHALL have parameter TOL, default 2, giving the allowed absolute error in cycles between the measured and programmed interval.
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port GO  input  1  request one measurement; sampled in IDLE only.
REQ-007 SHALL have port ABORT  input  1  synchronous cancel of the measurement in progress.
REQ-008 SHALL have port INTERVAL  input  32  programmed cycles from START rise to STOP rise; latched on accepted GO.
REQ-009 SHALL have port LAIKAS  input  32  elapsed-time count returned by the timer under test.
REQ-010 SHALL have port START  output  1  start pulse to the timer, registered.
REQ-011 SHALL have port STOP  output  1  stop pulse to the timer, registered.
REQ-012 SHALL have port BUSY  output  1  measurement in progress.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse when MEAS and ERR are updated.
REQ-014 SHALL have port MEAS  output  32  LAIKAS value captured at the end of the last completed measurement.
REQ-015 SHALL have port ERR  output  1  high when |MEAS - INTERVAL_latched| > TOL for the last completed measurement.

Function
REQ-016 SHALL implement the FSM IDLE -> START_P -> GAP -> STOP_P -> SETTLE_W -> DONE_S -> IDLE, using a single 32-bit down-counter shared across states.
REQ-017 SHALL accept GO high at an edge in IDLE (edge k), latch INTERVAL, and drive START high for cycles k+1 .. k+PW.
REQ-018 SHALL raise STOP exactly INTERVAL_eff cycles after START rises and hold it high for PW cycles; INTERVAL_eff = max(INTERVAL, PW+1).
REQ-019 SHALL never assert START and STOP in the same cycle.
REQ-020 SHALL sample LAIKAS into MEAS exactly SETTLE cycles after STOP falls, and pulse DONE high for that one cycle (DONE_S).
REQ-021 SHALL update ERR in the same cycle as MEAS, computing the difference as a 33-bit signed value (LAIKAS - INTERVAL_eff) with no wrap.
REQ-022 SHALL drive BUSY high from cycle k+1 through the DONE cycle inclusive, and low in IDLE.
REQ-023 SHALL ignore GO while BUSY; a held GO SHALL start a new measurement on the first IDLE edge following DONE.
REQ-024 SHALL, on ABORT high in any non-IDLE state, enter IDLE at the next edge: START, STOP and BUSY go low; no DONE pulse; MEAS and ERR unchanged.
REQ-025 SHALL give ABORT priority over GO when both are high in the same IDLE cycle (GO ignored).
REQ-026 SHALL treat INTERVAL = 0 as PW+1 per REQ-018, with ERR computed against PW+1.
REQ-027 SHALL complete a full-scale 32-bit INTERVAL (0xFFFFFFFF) with no counter wrap.

Reset
REQ-028 SHALL, while RESET is low, asynchronously force: state IDLE; START, STOP, BUSY, DONE and ERR to 0; MEAS to 0; latched interval and counter to 0.
REQ-029 SHALL, on reset assertion mid-measurement, drop START and STOP immediately (not clock-aligned).
REQ-030 SHALL accept no GO at the first clock edge on which RESET is already high; GO SHALL be accepted from the second edge after release.

Verification
REQ-031 Bench SHALL check the nominal case: PW=3, SETTLE=4, INTERVAL=100, GO pulse at edge 10, LAIKAS=100 -> START high cycles 11-13; STOP high cycles 111-113; DONE at cycle 117; MEAS=100; ERR=0; BUSY high cycles 11-117.
REQ-032 Bench SHALL check the tolerance boundary: INTERVAL=100 with LAIKAS=102 -> ERR=0; with LAIKAS=103 -> ERR=1; with LAIKAS=97 -> ERR=1.
REQ-033 Bench SHALL check the clamp: INTERVAL=0 with PW=3 -> STOP rises 4 cycles after START rises; START and STOP never overlap; LAIKAS=4 -> ERR=0.
REQ-034 Bench SHALL check abort: ABORT at cycle 50 of the REQ-031 run -> IDLE at cycle 51; no STOP pulse; no DONE; MEAS and ERR keep their prior values; a subsequent GO is accepted normally.
REQ-035 Bench SHALL check GO while busy: GO pulsed at cycle 60 of the REQ-031 run -> ignored, exactly one DONE; GO held high continuously -> back-to-back measurements, with START rising on the cycle after each DONE plus one.
REQ-036 Bench SHALL check reset mid-STOP: RESET low at cycle 112 -> STOP low immediately; all outputs 0; MEAS=0 after release.
